// File: rtl/data_2x2_inv_transform.sv
// Winograd F(2x2,3x3) output transform: accumulates 4x4 product tiles over channels, then Y = A^T*M*A.
// out_valid rises two edges after the in_last beat is accepted; the input stalls in ROW/COL and follows out_ready in OUT.
module data_2x2_inv_transform #(
   parameter int IW    = 16,
   parameter int ACC_W = 24,
   parameter int OW    = ACC_W + 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic [16*IW-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4*OW-1:0]  out_data
);

   localparam int TW = ACC_W + 2;

   typedef enum logic [1:0] {ACC, ROW, COL, OUT} state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic                     first;
   logic                     accept;
   logic signed [ACC_W-1:0]  beat  [16];
   logic signed [ACC_W-1:0]  acc   [16];
   logic signed [TW-1:0]     t0    [4];
   logic signed [TW-1:0]     t1    [4];
   logic signed [TW-1:0]     t0_nxt[4];
   logic signed [TW-1:0]     t1_nxt[4];
   logic        [4*OW-1:0]   y_nxt;

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ACC;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ACC: begin
            in_ready = 1'b1;
            if (in_valid && in_last) state_nxt = ROW;
         end
         ROW: state_nxt = COL;
         COL: state_nxt = OUT;
         OUT: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) state_nxt = (in_valid && in_last) ? ROW : ACC;
         end
         default: state_nxt = ACC;
      endcase
   end

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         beat[i] = {{(ACC_W-IW){in_data[i*IW+IW-1]}}, in_data[i*IW +: IW]};
      end
   end

   // Accumulators are free once stage 1 has captured them, so OUT may reload them.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         first <= 1'b1;
         for (int i = 0; i < 16; i++) acc[i] <= '0;
      end else if (accept) begin
         first <= in_last;
         for (int i = 0; i < 16; i++) acc[i] <= first ? beat[i] : acc[i] + beat[i];
      end
   end

   always_comb begin
      for (int c = 0; c < 4; c++) begin
         logic signed [TW-1:0] a0, a1, a2, a3;
         a0 = {{2{acc[c][ACC_W-1]}},    acc[c]};
         a1 = {{2{acc[4+c][ACC_W-1]}},  acc[4+c]};
         a2 = {{2{acc[8+c][ACC_W-1]}},  acc[8+c]};
         a3 = {{2{acc[12+c][ACC_W-1]}}, acc[12+c]};
         t0_nxt[c] = a0 + a1 + a2;
         t1_nxt[c] = a1 - a2 - a3;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int c = 0; c < 4; c++) begin
            t0[c] <= '0;
            t1[c] <= '0;
         end
      end else if (state == ROW) begin
         for (int c = 0; c < 4; c++) begin
            t0[c] <= t0_nxt[c];
            t1[c] <= t1_nxt[c];
         end
      end
   end

   always_comb begin
      logic signed [OW-1:0] e0 [4];
      logic signed [OW-1:0] e1 [4];
      for (int c = 0; c < 4; c++) begin
         e0[c] = {{(OW-TW){t0[c][TW-1]}}, t0[c]};
         e1[c] = {{(OW-TW){t1[c][TW-1]}}, t1[c]};
      end
      y_nxt            = '0;
      y_nxt[0*OW +: OW] = e0[0] + e0[1] + e0[2];
      y_nxt[1*OW +: OW] = e0[1] - e0[2] - e0[3];
      y_nxt[2*OW +: OW] = e1[0] + e1[1] + e1[2];
      y_nxt[3*OW +: OW] = e1[1] - e1[2] - e1[3];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)             out_data <= '0;
      else if (state == COL) out_data <= y_nxt;
   end

endmodule

// File: tb/tb_data_2x2_inv_transform.sv
// Bench for data_2x2_inv_transform: vector table, hand sequences and a scoreboard of expected output tiles.
module tb_data_2x2_inv_transform;

   localparam int IW    = 16;
   localparam int ACC_W = 24;
   localparam int OW    = ACC_W + 4;
   localparam int DW    = 16*IW;
   localparam int YW    = 4*OW;

   logic          clk = 1'b0;
   logic          rstn;
   logic          in_valid;
   logic          in_ready;
   logic          in_last;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [YW-1:0] out_data;

   int errors = 0;
   int checks = 0;
   logic [YW-1:0] sb [$];

   typedef struct {
      int            nb;
      int            val;
      int            pos;
      logic [YW-1:0] y;
   } vec_t;

   vec_t vecs [4];

   data_2x2_inv_transform #(.IW(IW), .ACC_W(ACC_W), .OW(OW)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .in_data(in_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [YW-1:0] act, input logic [YW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [YW-1:0] pack_y(input int y00, input int y01, input int y10, input int y11);
      logic [YW-1:0] r;
      r = '0;
      r[0*OW +: OW] = OW'(y00);
      r[1*OW +: OW] = OW'(y01);
      r[2*OW +: OW] = OW'(y10);
      r[3*OW +: OW] = OW'(y11);
      return r;
   endfunction

   function automatic logic [DW-1:0] fill(input int val, input int pos);
      logic [DW-1:0] d;
      d = '0;
      for (int i = 0; i < 16; i++)
         if (pos < 0 || pos == i) d[i*IW +: IW] = IW'(val);
      return d;
   endfunction

   // Direct A^T*M*A over the wrapped channel sums.
   function automatic logic [YW-1:0] model_y(input int m [16]);
      int at [2][4];
      longint y;
      logic [YW-1:0] r;
      at = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};
      r  = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            y = 0;
            for (int rr = 0; rr < 4; rr++)
               for (int cc = 0; cc < 4; cc++)
                  y += longint'(at[i][rr]) * longint'(m[rr*4+cc]) * longint'(at[j][cc]);
            r[(i*2+j)*OW +: OW] = OW'(y);
         end
      return r;
   endfunction

   // Called away from the clock edge; returns 1ns after the accepting edge.
   task automatic send_beat(input logic [DW-1:0] d, input logic last);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      #1;
      while (!in_ready && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         errors++;
         checks++;
         $display("FAIL send_beat: in_ready stuck low after %0d cycles", n);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_pending", YW'(sb.size()), '0);
   endtask

   always @(negedge clk) begin
      if (rstn && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tile: got %h with empty scoreboard", out_data);
         end else begin
            check("tile", out_data, sb.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int m [16];
      logic [DW-1:0] d;
      logic signed [ACC_W-1:0] w;

      vecs[0] = '{3,  2, -1, pack_y(54, -18, -18, 6)};
      vecs[1] = '{1,  5,  5, pack_y(5, 5, 5, 5)};
      vecs[2] = '{1,  7, 15, pack_y(0, 0, 0, 7)};
      vecs[3] = '{1, -1, -1, pack_y(-9, 3, 3, -1)};

      rstn = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", YW'(out_valid), YW'(0));
      check("rst_in_ready",  YW'(in_ready),  YW'(1));
      check("rst_out_data",  out_data, '0);
      rstn = 1'b1;
      @(posedge clk); #1;

      // Single beat of ones: latency and stall during ROW/COL.
      sb.push_back(pack_y(9, -3, -3, 1));
      send_beat(fill(1, -1), 1'b1);
      check("lat_row_in_ready",  YW'(in_ready),  YW'(0));
      check("lat_row_out_valid", YW'(out_valid), YW'(0));
      @(posedge clk); #1;
      check("lat_col_in_ready",  YW'(in_ready),  YW'(0));
      check("lat_col_out_valid", YW'(out_valid), YW'(0));
      @(posedge clk); #1;
      check("lat_out_valid", YW'(out_valid), YW'(1));
      drain();

      for (int v = 0; v < 4; v++) begin
         sb.push_back(vecs[v].y);
         for (int b = 0; b < vecs[v].nb; b++)
            send_beat(fill(vecs[v].val, vecs[v].pos), b == vecs[v].nb - 1);
         drain();
      end
      check("out_data_retained", out_data, pack_y(-9, 3, 3, -1));

      // Backpressure, then simultaneous output take and input accept.
      out_ready = 1'b0;
      sb.push_back(pack_y(9, -3, -3, 1));
      send_beat(fill(1, -1), 1'b1);
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b1; in_last = 1'b1; in_data = fill(3, -1);
      for (int k = 0; k < 5; k++) begin
         check("bp_out_valid", YW'(out_valid), YW'(1));
         check("bp_in_ready",  YW'(in_ready),  YW'(0));
         check("bp_out_data",  out_data, pack_y(9, -3, -3, 1));
         @(posedge clk); #1;
      end
      out_ready = 1'b1; in_last = 1'b0; in_data = fill(1, -1);
      #1;
      check("bp_release_in_ready", YW'(in_ready), YW'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_after_out_valid", YW'(out_valid), YW'(0));
      check("bp_after_in_ready",  YW'(in_ready),  YW'(1));
      check("bp_after_sb",        YW'(sb.size()), '0);
      sb.push_back(pack_y(18, -6, -6, 2));
      send_beat(fill(1, -1), 1'b1);
      drain();

      // Reset in the middle of accumulation.
      send_beat(fill(1, -1), 1'b0);
      send_beat(fill(1, -1), 1'b0);
      rstn = 1'b0;
      #1;
      check("mid_rst_out_valid", YW'(out_valid), YW'(0));
      check("mid_rst_in_ready",  YW'(in_ready),  YW'(1));
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      sb.push_back(pack_y(9, -3, -3, 1));
      send_beat(fill(1, -1), 1'b1);
      drain();

      // Random three-beat tile against the direct model.
      for (int i = 0; i < 16; i++) m[i] = 0;
      for (int b = 0; b < 3; b++) begin
         d = '0;
         for (int i = 0; i < 16; i++) begin
            d[i*IW +: IW] = IW'($urandom);
            w = ACC_W'(m[i] + int'($signed(d[i*IW +: IW])));
            m[i] = int'(w);
         end
         if (b == 2) sb.push_back(model_y(m));
         send_beat(d, b == 2);
      end
      drain();

      // Long tile that wraps the accumulators.
      for (int i = 0; i < 16; i++) m[i] = 0;
      for (int b = 0; b < 260; b++)
         for (int i = 0; i < 16; i++) begin
            w = ACC_W'(m[i] + 32767);
            m[i] = int'(w);
         end
      sb.push_back(model_y(m));
      for (int b = 0; b < 260; b++) send_beat(fill(32767, -1), b == 259);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
